// File: rtl/serial_detect_sched_if.sv
// Requester/result bundle for serial_detect_sched: producers drive the master side,
// the scheduler sits on the slave side.
interface serial_detect_sched_if #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 8,
  parameter int CNT_W  = 4,
  parameter int ID_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1
);
  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic [N_REQ-1:0]        req_ready;
  logic                    busy;
  logic                    ser_bit;
  logic                    det_hit;
  logic                    res_valid;
  logic [ID_W-1:0]         res_id;
  logic [CNT_W-1:0]        res_count;

  modport master (
    output req_valid, req_data,
    input  req_ready, busy, ser_bit, det_hit, res_valid, res_id, res_count
  );

  modport slave (
    input  req_valid, req_data,
    output req_ready, busy, ser_bit, det_hit, res_valid, res_id, res_count
  );
endinterface

// File: rtl/serial_detect_sched.sv
// Round-robin scheduler sharing one MSB-first, non-overlapping pattern detector
// among N_REQ word producers; reports the match count of each granted word.
//
// state  | meaning
// IDLE   | engine free, round-robin grant offered combinationally on req_ready
// SHIFT  | DATA_W cycles, one bit consumed per edge through the detection window
// REPORT | res_valid pulse with res_id/res_count of the finished word
module serial_detect_sched #(
  parameter int              N_REQ   = 4,
  parameter int              DATA_W  = 8,
  parameter int              PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = 4'b1010,
  parameter int              CNT_W   = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  serial_detect_sched_if.slave bus
);
  localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int BC_W = $clog2(DATA_W);
  localparam int WF_W = $clog2(PAT_W);

  typedef enum logic [1:0] {IDLE, SHIFT, REPORT} state_t;

  state_t            state;
  logic [DATA_W-1:0] shreg;
  logic [PAT_W-2:0]  win;
  logic [WF_W-1:0]   wfill;
  logic [BC_W-1:0]   bit_cnt;
  logic [ID_W-1:0]   last_grant;
  logic [ID_W-1:0]   res_id_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              det_hit_q;
  logic              res_valid_q;

  logic [N_REQ-1:0]  grant_oh;
  logic [ID_W-1:0]   grant_id;
  logic              grant_any;
  logic [ID_W-1:0]   idx;
  logic [DATA_W-1:0] sel_word;
  logic [PAT_W-1:0]  win_nxt;
  logic              match;

  // Search starts one past the last winner; reset also masks the offer so a
  // request in a reset cycle is never accepted.
  always_comb begin
    grant_oh  = '0;
    grant_id  = '0;
    grant_any = 1'b0;
    idx       = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = ID_W'((int'(last_grant) + k) % N_REQ);
      if (!grant_any && bus.req_valid[idx]) begin
        grant_any     = 1'b1;
        grant_id      = idx;
        grant_oh[idx] = 1'b1;
      end
    end
    if (state != IDLE || !reset_n) begin
      grant_oh  = '0;
      grant_any = 1'b0;
    end
  end

  always_comb begin
    sel_word = bus.req_data[int'(grant_id)*DATA_W +: DATA_W];
    win_nxt  = {win, shreg[DATA_W-1]};
    match    = (wfill == WF_W'(PAT_W-1)) && (win_nxt == PATTERN);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= IDLE;
      shreg       <= '0;
      win         <= '0;
      wfill       <= '0;
      bit_cnt     <= '0;
      last_grant  <= ID_W'(N_REQ-1);
      res_id_q    <= '0;
      cnt_q       <= '0;
      det_hit_q   <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          det_hit_q   <= 1'b0;
          res_valid_q <= 1'b0;
          if (grant_any) begin
            shreg      <= sel_word;
            res_id_q   <= grant_id;
            last_grant <= grant_id;
            win        <= '0;
            wfill      <= '0;
            cnt_q      <= '0;
            bit_cnt    <= BC_W'(DATA_W-1);
            state      <= SHIFT;
          end
        end
        SHIFT: begin
          shreg     <= shreg << 1;
          det_hit_q <= match;
          // A match restarts the window so matches never share bits.
          if (match) begin
            cnt_q <= cnt_q + CNT_W'(1);
            win   <= '0;
            wfill <= '0;
          end else begin
            win <= win_nxt[PAT_W-2:0];
            if (wfill != WF_W'(PAT_W-1)) wfill <= wfill + WF_W'(1);
          end
          if (bit_cnt == '0) begin
            state       <= REPORT;
            res_valid_q <= 1'b1;
          end else begin
            bit_cnt <= bit_cnt - BC_W'(1);
          end
        end
        REPORT: begin
          res_valid_q <= 1'b0;
          det_hit_q   <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready = grant_oh;
  assign bus.busy      = (state != IDLE);
  assign bus.ser_bit   = shreg[DATA_W-1];
  assign bus.det_hit   = det_hit_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_id    = res_id_q;
  assign bus.res_count = cnt_q;
endmodule

// File: tb/tb_serial_detect_sched.sv
// Scoreboard bench for serial_detect_sched: requester model, grant/result monitor
// and directed scenarios with hand-computed counts and det_hit cycle maps.
module tb_serial_detect_sched;
  logic clk;
  logic reset_n;
  int   cyc;
  int   n_vec;
  int   n_err;

  typedef struct {
    int gid;
    int cnt;
    int hits;   // bit k set: det_hit expected in cycle accept+k
    bit abort;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] wq[4][$];
  int         hold[4];
  int         acc_t[$];

  serial_detect_sched_if bus ();

  serial_detect_sched dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic flag(input string nm, input int v);
    n_vec++;
    n_err++;
    $display("FAIL %s: value %0d (cycle %0d)", nm, v, cyc);
  endtask

  // Requester model: holds valid/data until accepted, then drops valid for a cycle.
  initial begin
    logic [3:0] acc;
    bus.req_valid = '0;
    bus.req_data  = '0;
    forever begin
      @(negedge clk);
      acc = bus.req_valid & bus.req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
        if (acc[i]) begin
          bus.req_valid[i] = 1'b0;
          void'(wq[i].pop_front());
        end else if (!bus.req_valid[i] && wq[i].size() > 0 && cyc >= hold[i]) begin
          bus.req_data[i*8 +: 8] = wq[i][0];
          bus.req_valid[i]       = 1'b1;
        end
      end
    end
  end

  // Monitor: checks each grant and each result against the scoreboard head.
  initial begin
    int   t0;
    int   hits;
    int   id;
    bit   trk;
    exp_t e;
    trk = 1'b0;
    t0 = 0;
    hits = 0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        if (trk && exp_q.size() > 0 && exp_q[0].abort) void'(exp_q.pop_front());
        trk = 1'b0;
        continue;
      end
      if (|(bus.req_valid & bus.req_ready)) begin
        id = 0;
        for (int i = 0; i < 4; i++) if (bus.req_ready[i]) id = i;
        acc_t.push_back(cyc);
        if (exp_q.size() == 0) flag("unexpected_grant", id);
        else chk("grant_id", 32'(id), 32'(exp_q[0].gid));
        trk  = 1'b1;
        t0   = cyc;
        hits = 0;
      end else if (trk && bus.det_hit && (cyc - t0) < 31) begin
        hits |= (1 << (cyc - t0));
      end
      if (bus.res_valid) begin
        if (!trk || exp_q.size() == 0) begin
          flag("unexpected_result", 32'(bus.res_id));
        end else begin
          e = exp_q.pop_front();
          chk("res_id", 32'(bus.res_id), 32'(e.gid));
          chk("res_count", 32'(bus.res_count), 32'(e.cnt));
          chk("det_hit_map", 32'(hits), 32'(e.hits));
          chk("res_latency", 32'(cyc - t0), 32'd9);
          chk("busy_in_report", 32'(bus.busy), 32'd1);
          trk = 1'b0;
        end
      end
    end
  end

  task automatic send(input int r, input logic [7:0] w, input int cnt, input int hits,
                      input bit abort);
    exp_t e;
    e.gid = r;
    e.cnt = cnt;
    e.hits = hits;
    e.abort = abort;
    exp_q.push_back(e);
    wq[r].push_back(w);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_req_ready"}, 32'(bus.req_ready), 32'd0);
    chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
    chk({tag, "_ser_bit"}, 32'(bus.ser_bit), 32'd0);
    chk({tag, "_det_hit"}, 32'(bus.det_hit), 32'd0);
    chk({tag, "_res_valid"}, 32'(bus.res_valid), 32'd0);
    chk({tag, "_res_id"}, 32'(bus.res_id), 32'd0);
    chk({tag, "_res_count"}, 32'(bus.res_count), 32'd0);
  endtask

  task automatic wait_drain(input string tag);
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      #1;
      if (exp_q.size() == 0 && wq[0].size() == 0 && wq[1].size() == 0 &&
          wq[2].size() == 0 && wq[3].size() == 0 && !bus.busy) return;
    end
    flag({tag, "_drain_timeout"}, exp_q.size());
    exp_q.delete();
    for (int i = 0; i < 4; i++) wq[i].delete();
  endtask

  task automatic wait_acc(input string tag, input int n);
    for (int k = 0; k < 200; k++) begin
      if (acc_t.size() >= n) return;
      @(negedge clk);
      #1;
    end
    flag({tag, "_accept_timeout"}, acc_t.size());
  endtask

  task automatic do_reset(input string tag);
    @(posedge clk);
    #1 reset_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_zero(tag);
    @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  initial begin
    int base;
    int t;
    n_vec = 0;
    n_err = 0;
    for (int i = 0; i < 4; i++) hold[i] = 0;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_zero("por");
    @(posedge clk);
    #1 reset_n = 1'b1;

    // Basic match count and non-overlap
    @(negedge clk);
    send(0, 8'hAA, 2, 'h220, 1'b0);
    wait_drain("basic");
    send(1, 8'hD4, 1, 'h040, 1'b0);
    send(1, 8'h00, 0, 'h000, 1'b0);
    wait_drain("nonoverlap");

    // Round-robin: words presented while reset is held must not be taken
    @(posedge clk);
    #1 reset_n = 1'b0;
    base = acc_t.size();
    send(0, 8'hAA, 2, 'h220, 1'b0);
    send(1, 8'hD4, 1, 'h040, 1'b0);
    send(2, 8'h0A, 1, 'h200, 1'b0);
    send(3, 8'h55, 1, 'h040, 1'b0);
    send(0, 8'hA0, 1, 'h020, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_valid_held", 32'(bus.req_valid), 32'hF);
    chk_zero("rst_with_valid");
    @(posedge clk);
    #1 reset_n = 1'b1;
    wait_drain("round_robin");
    if (acc_t.size() >= base + 5) begin
      for (int k = 1; k < 5; k++)
        chk("rr_accept_gap", 32'(acc_t[base+k] - acc_t[base+k-1]), 32'd10);
    end else begin
      flag("rr_accept_count", acc_t.size() - base);
    end

    // Fairness with requester 0 re-asserting after each grant
    do_reset("rst_fair");
    @(negedge clk);
    send(0, 8'hAA, 2, 'h220, 1'b0);
    send(2, 8'hD4, 1, 'h040, 1'b0);
    send(0, 8'h00, 0, 'h000, 1'b0);
    send(2, 8'h5A, 1, 'h200, 1'b0);
    wait_drain("fairness");

    // Valid raised in the REPORT cycle is taken only in the following IDLE cycle
    base = acc_t.size();
    send(3, 8'hFF, 0, 'h000, 1'b0);
    wait_acc("b2b_first", base + 1);
    t = (acc_t.size() > base) ? acc_t[base] : cyc;
    hold[1] = t + 9;
    send(1, 8'h5A, 1, 'h200, 1'b0);
    while (cyc < t + 9) @(negedge clk);
    chk("b2b_report_valid", 32'(bus.res_valid), 32'd1);
    chk("b2b_req_valid", 32'(bus.req_valid[1]), 32'd1);
    chk("b2b_no_ready_in_report", 32'(bus.req_ready), 32'd0);
    wait_drain("back_to_back");
    if (acc_t.size() >= base + 2) chk("b2b_accept_gap", 32'(acc_t[base+1] - acc_t[base]), 32'd10);
    else flag("b2b_accept_count", acc_t.size() - base);

    // Reset in the 4th SHIFT cycle discards the word
    base = acc_t.size();
    send(2, 8'hAA, 0, 'h000, 1'b1);
    wait_acc("midrst", base + 1);
    t = (acc_t.size() > base) ? acc_t[base] : cyc;
    while (cyc < t + 4) begin
      @(posedge clk);
      #1;
    end
    reset_n = 1'b0;
    @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    chk_zero("midrst");
    chk("midrst_word_dropped", 32'(exp_q.size()), 32'd0);
    send(0, 8'hA0, 1, 'h020, 1'b0);
    send(3, 8'h0A, 1, 'h200, 1'b0);
    wait_drain("after_midrst");

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    repeat (20000) @(posedge clk);
    $display("FAIL watchdog: simulation exceeded cycle budget at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
endmodule
